// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and pipeline-register payload types
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int DEST_W = 4;

   // Payload carried by the EXE/MEM and MEM/WB pipeline registers.
   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic              mem_r_en;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] data;
      logic [DEST_W-1:0] dest;
   } mem_wb_t;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with sync active-low reset, hold and clear
module pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             hold_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next state: hold beats clear, clear beats load.
   always_comb begin
      q_d = d_i;
      if (hold_i) begin
         q_d = q_q;
      end else if (clear_i) begin
         q_d = '0;
      end
   end

   // State register; reset overrides hold and clear.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register, write-back select and retire counter
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              valid_in,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              wb_write,
   output logic [DEST_W-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_value,
   output logic              fwd_valid,
   output logic [DEST_W-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_value,
   output logic [CNT_W-1:0]  retired_cnt
);

   mem_wb_t          stage_d;
   mem_wb_t          stage_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Pack the MEM-side inputs into the shared payload.
   always_comb begin
      stage_d          = '0;
      stage_d.valid    = valid_in;
      stage_d.wb_en    = wb_en_in;
      stage_d.mem_r_en = mem_r_en_in;
      stage_d.alu      = alu_res_in;
      stage_d.data     = mem_data_in;
      stage_d.dest     = dest_in;
   end

   pipe_reg #(
      .WIDTH($bits(mem_wb_t))
   ) u_pipe_reg (
      .clk_i  (clk),
      .rstn_i (rst),
      .hold_i (freeze),
      .clear_i(flush),
      .d_i    (stage_d),
      .q_o    (stage_q)
   );

   // Write-back select; load data is only chosen for loads so stray data never leaks.
   always_comb begin
      wb_write = stage_q.valid & stage_q.wb_en;
      wb_dest  = stage_q.dest;
      wb_value = stage_q.mem_r_en ? stage_q.data : stage_q.alu;
   end

   assign fwd_valid = wb_write;
   assign fwd_dest  = wb_dest;
   assign fwd_value = wb_value;

   // Retire counter: an instruction retires when it leaves a non-frozen WB slot.
   always_comb begin
      cnt_d = cnt_q;
      if (!freeze && wb_write) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with sync active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign retired_cnt = cnt_q;

endmodule
